pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
- Power-up and recovery sequencer that pairs with the design's PLL wrapper, running in the opposite direction to it.
- Drives the PLL's rst input and consumes its asynchronous locked output.
- Releases the system reset only after a debounced, stable lock.
- Runs on the free-running 50 MHz reference clock so it operates while the PLL is unlocked. It re-sequences automatically on lock loss or lock timeout.

Parameters:
RST_CYCLES, 16, cycles pll_rst is held high per PLL reset pulse (>=2)
LOCK_STABLE, 1024, consecutive synchronised-locked cycles required before release (>=2)
LOCK_TIMEOUT, 65536, max cycles waiting for lock before re-pulsing pll_rst (>=2)
CNT_W, 17, counter width; must hold max(RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT)-1

Ports:
refclk  in  1  free-running reference clock (50 MHz); sole clock
rst  in  1  synchronous active-high reset
locked  in  1  PLL lock indicator, asynchronous to refclk
pll_rst  out  1  reset to PLL, active high
sys_reset  out  1  system reset, active high
ready  out  1  high while sequencer is in RUN
relock_count  out  8  number of lock losses seen in RUN, saturating at 255
seq_state  out  2  current state: 0 PLL_RESET, 1 WAIT_LOCK, 2 STABLE, 3 RUN

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named refclk and rst.
- locked passes a 2-flop synchroniser (sync1, sync2=locked_s) before use. The synchroniser flops clear on rst.
- Single counter cnt (CNT_W bits). cnt clears on every state change.
- All outputs are registered and decoded from the next state, so they align with seq_state.
- rst=1 forces: state PLL_RESET, cnt=0, sync flops=0, pll_rst=1, sys_reset=1, ready=0, relock_count=0. This applies equally mid-operation.
- PLL_RESET: pll_rst=1, sys_reset=1, ready=0.
  - If cnt==RST_CYCLES-1, go to WAIT_LOCK; else cnt++.
  - pll_rst stays high exactly RST_CYCLES cycles after the first edge with rst=0.
- WAIT_LOCK: pll_rst=0, sys_reset=1.
  - If locked_s=1, go to STABLE.
  - Else if cnt==LOCK_TIMEOUT-1, go to PLL_RESET (timeout; relock_count unchanged).
  - Else cnt++.
- STABLE: pll_rst=0, sys_reset=1.
  - If locked_s=0, go to WAIT_LOCK (glitch; cnt restarts).
  - Else if cnt==LOCK_STABLE-1, go to RUN.
  - Else cnt++.
- RUN: pll_rst=0, sys_reset=0, ready=1.
  - If locked_s=0, go to PLL_RESET and relock_count += 1, saturating at 255.
- locked_s=0 in STABLE on the same edge cnt==LOCK_STABLE-1: the lock-loss branch wins (goes to WAIT_LOCK, not RUN).
- Latency, lock to release: edge e0 samples locked=1. Entry to STABLE follows after e2. ready=1 and sys_reset=0 follow after edge e0+LOCK_STABLE+2 if locked is held.
- Latency, lock loss: edge f0 samples locked=0. sys_reset=1, ready=0 and pll_rst=1 follow after edge f2.
- Boundary conditions:
  - locked already high when pll_rst releases: the sequence proceeds normally.
  - locked toggling faster than the synchroniser: only locked_s matters.
  - cnt never wraps, because the terminal compares precede the increment.

Test Plan:
- Parameters for all tests: RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32.
1. rst high 5 cycles, then low, locked=0 → pll_rst=1 for exactly 4 cycles after rst release, then 0; seq_state=1; sys_reset=1; ready=0; relock_count=0.
2. After test 1, locked rises and holds; first sampling edge e0 → seq_state=2 after e2; ready=1 and sys_reset=0 after e10; seq_state=3.
3. locked stays low in WAIT_LOCK → after 32 cycles pll_rst pulses high for 4 cycles, then WAIT_LOCK resumes; pattern repeats; relock_count stays 0.
4. In STABLE, locked drops for 3 cycles after 5 good cycles, then returns → back to WAIT_LOCK; ready is reached 10 edges after the re-sampled rise, never earlier.
5. In RUN, locked drops at edge f0 → after f2: sys_reset=1, ready=0, pll_rst=1, relock_count=1. Repeat the loss 260 times → relock_count=255 and holds.
6. Assert rst during RUN with relock_count=3 → on the next edge: seq_state=0, pll_rst=1, sys_reset=1, ready=0, relock_count=0, synchroniser cleared.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// PLL power-up / recovery sequencer on the free-running reference clock.
// Pulses the PLL reset, waits for a debounced lock, then releases system reset.
module pll_lock_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int CNT_W        = 17
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic [7:0] relock_count,
    output logic [1:0] seq_state
);

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             sync1;
    logic             locked_s;
    logic             pll_rst_n;
    logic             sys_reset_n;
    logic             ready_n;
    logic [7:0]       relock_n;

    // Two-flop synchroniser bringing the asynchronous lock flag into refclk
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= locked;
            locked_s <= sync1;
        end
    end

    // State and shared counter registers
    always_ff @(posedge refclk) begin
        if (rst) begin
            state <= PLL_RESET;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Next-state and counter logic; terminal compares precede the increment
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            PLL_RESET: begin
                if (cnt == RST_LAST) begin
                    state_n = WAIT_LOCK;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_n = STABLE;
                end else if (cnt == TMO_LAST) begin
                    state_n = PLL_RESET;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_n = WAIT_LOCK;
                end else if (cnt == STAB_LAST) begin
                    state_n = RUN;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_n = PLL_RESET;
                end
            end
            default: begin
                state_n = PLL_RESET;
            end
        endcase
        if (state_n != state) begin
            cnt_n = '0;
        end
    end

    // Output decode from the next state so registered outputs track seq_state
    always_comb begin
        pll_rst_n   = (state_n == PLL_RESET);
        sys_reset_n = (state_n != RUN);
        ready_n     = (state_n == RUN);
        relock_n    = relock_count;
        if (state == RUN && !locked_s && relock_count != 8'hFF) begin
            relock_n = relock_count + 8'd1;
        end
    end

    // Registered outputs
    always_ff @(posedge refclk) begin
        if (rst) begin
            pll_rst      <= 1'b1;
            sys_reset    <= 1'b1;
            ready        <= 1'b0;
            relock_count <= 8'd0;
        end else begin
            pll_rst      <= pll_rst_n;
            sys_reset    <= sys_reset_n;
            ready        <= ready_n;
            relock_count <= relock_n;
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer.
// Small parameters: RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32.
module tb_pll_lock_sequencer;

    logic       refclk = 1'b0;
    logic       rst;
    logic       locked;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic [7:0] relock_count;
    logic [1:0] seq_state;

    int n_run  = 0;
    int n_fail = 0;

    pll_lock_sequencer #(
        .RST_CYCLES  (4),
        .LOCK_STABLE (8),
        .LOCK_TIMEOUT(32),
        .CNT_W       (17)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .pll_rst     (pll_rst),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .relock_count(relock_count),
        .seq_state   (seq_state)
    );

    always #10 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget,
                              input string tag);
        int n;
        n = 0;
        while (seq_state !== s && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(seq_state), 32'(s));
    endtask

    initial begin
        rst    = 1'b1;
        locked = 1'b0;

        // Test 1: reset, then exactly 4 cycles of pll_rst
        repeat (5) tick();
        chk("rst_state", 32'(seq_state), 0);
        chk("rst_pll", 32'(pll_rst), 1);
        chk("rst_sys", 32'(sys_reset), 1);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_relock", 32'(relock_count), 0);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("t1_pll_%0d", i), 32'(pll_rst), (i < 4) ? 1 : 0);
        end
        chk("t1_state", 32'(seq_state), 1);
        chk("t1_sys", 32'(sys_reset), 1);
        chk("t1_ready", 32'(ready), 0);
        chk("t1_relock", 32'(relock_count), 0);

        // Test 3: timeout after 32 cycles in WAIT_LOCK, re-pulse 4 cycles
        for (int r = 0; r < 2; r++) begin
            repeat (31) tick();
            chk($sformatf("t3_wait_%0d", r), 32'(seq_state), 1);
            tick();
            chk($sformatf("t3_tmo_%0d", r), 32'(seq_state), 0);
            chk($sformatf("t3_pll_%0d", r), 32'(pll_rst), 1);
            repeat (3) tick();
            chk($sformatf("t3_hold_%0d", r), 32'(pll_rst), 1);
            tick();
            chk($sformatf("t3_rel_%0d", r), 32'(pll_rst), 0);
            chk($sformatf("t3_st_%0d", r), 32'(seq_state), 1);
            chk($sformatf("t3_relock_%0d", r), 32'(relock_count), 0);
        end

        // Test 2: lock rises; STABLE after e2, RUN after e10
        locked = 1'b1;
        tick();
        tick();
        chk("t2_e1", 32'(seq_state), 1);
        tick();
        chk("t2_e2", 32'(seq_state), 2);
        repeat (7) tick();
        chk("t2_e9_st", 32'(seq_state), 2);
        chk("t2_e9_rdy", 32'(ready), 0);
        tick();
        chk("t2_e10_st", 32'(seq_state), 3);
        chk("t2_e10_rdy", 32'(ready), 1);
        chk("t2_e10_sys", 32'(sys_reset), 0);
        chk("t2_e10_pll", 32'(pll_rst), 0);

        // Test 5: lock loss in RUN, then saturate relock_count
        locked = 1'b0;
        tick();
        tick();
        chk("t5_f1_rdy", 32'(ready), 1);
        tick();
        chk("t5_f2_st", 32'(seq_state), 0);
        chk("t5_f2_sys", 32'(sys_reset), 1);
        chk("t5_f2_rdy", 32'(ready), 0);
        chk("t5_f2_pll", 32'(pll_rst), 1);
        chk("t5_f2_cnt", 32'(relock_count), 1);
        for (int k = 2; k <= 260; k++) begin
            locked = 1'b1;
            wait_state(2'd3, 40, "t5_run");
            locked = 1'b0;
            wait_state(2'd0, 10, "t5_loss");
            if (k == 100) chk("t5_cnt100", 32'(relock_count), 100);
        end
        chk("t5_sat", 32'(relock_count), 255);

        // Test 4: glitch in STABLE, loss wins on the terminal count edge
        wait_state(2'd1, 10, "t4_wait");
        locked = 1'b1;
        repeat (3) tick();
        chk("t4_stable", 32'(seq_state), 2);
        repeat (5) tick();
        locked = 1'b0;
        repeat (2) tick();
        chk("t4_e9", 32'(seq_state), 2);
        tick();
        chk("t4_e10", 32'(seq_state), 1);
        locked = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            tick();
            chk($sformatf("t4_rdy_%0d", i), 32'(ready), (i == 10) ? 1 : 0);
            if (i == 2) chk("t4_g2", 32'(seq_state), 2);
        end
        chk("t4_sat_hold", 32'(relock_count), 255);

        // Test 6: rst in RUN with relock_count=3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            locked = 1'b1;
            wait_state(2'd3, 40, "t6_run");
            locked = 1'b0;
            wait_state(2'd0, 10, "t6_loss");
        end
        locked = 1'b1;
        wait_state(2'd3, 40, "t6_run3");
        chk("t6_pre_cnt", 32'(relock_count), 3);
        rst = 1'b1;
        tick();
        chk("t6_state", 32'(seq_state), 0);
        chk("t6_pll", 32'(pll_rst), 1);
        chk("t6_sys", 32'(sys_reset), 1);
        chk("t6_ready", 32'(ready), 0);
        chk("t6_cnt", 32'(relock_count), 0);
        chk("t6_sync1", 32'(dut.sync1), 0);
        chk("t6_sync2", 32'(dut.locked_s), 0);
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("t6_pll_%0d", i), 32'(pll_rst), (i < 4) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
